// File: rtl/common.sv
// Shared data-bus types and constants for the core/memory boundary.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dresp_state_t;

  localparam logic [15:0] DBUS_RESP_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle from a fixed seed.
module lfsr16
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= DBUS_RESP_LFSR_SEED;
    else       q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// SRAM-backed data-bus responder with fixed latency, or LATENCY..LATENCY+3 random
// wait states when DBUS_RESP_RANDSTALL_EN is defined. Outputs are fully registered.
module dbus_sram_responder
  import common::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int               IDX_W     = $clog2(MEM_WORDS);
  localparam int               CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_BASE  = CNT_W'(LATENCY - 1);
  localparam logic [63:0]      MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

  logic [63:0] mem [MEM_WORDS];

  dresp_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       extra;

  logic [IDX_W-1:0] req_idx;
  logic             req_in_range;
  logic [7:0]       req_strobe;
  logic [63:0]      req_data;

`ifdef DBUS_RESP_RANDSTALL_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign extra       = lfsr[1:0];
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign extra = 2'd0;
`endif

  // Decode of the live request; only meaningful on the accepting edge.
  logic [63:0]      offset;
  logic             in_range_in;
  logic [IDX_W-1:0] idx_in;
  logic             unused_bits;

  assign offset      = dreq.addr - BASE_ADDR;
  assign in_range_in = (dreq.addr >= BASE_ADDR) && (offset < MEM_BYTES);
  assign idx_in      = offset[IDX_W+2:3];
  assign unused_bits = ^{offset[63:IDX_W+3], offset[2:0], dreq.size};

  logic             accept;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_in_range;
  logic [7:0]       cur_strobe;
  dbus_resp_t       resp_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          accept  = 1'b1;
          cnt_n   = CNT_BASE + CNT_W'(extra);
          state_n = (cnt_n == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With a one-cycle latency the response is formed from the request being accepted.
  always_comb begin
    cur_idx      = accept ? idx_in       : req_idx;
    cur_in_range = accept ? in_range_in  : req_in_range;
    cur_strobe   = accept ? dreq.strobe  : req_strobe;
    resp_n       = '0;
    if (state_n == RESP) begin
      resp_n.addr_ok = 1'b1;
      resp_n.data_ok = 1'b1;
      if (cur_strobe == 8'h00 && cur_in_range) resp_n.data = mem[cur_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      dresp        <= '0;
      req_idx      <= '0;
      req_in_range <= 1'b0;
      req_strobe   <= '0;
      req_data     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dresp <= resp_n;
      if (accept) begin
        req_idx      <= idx_in;
        req_in_range <= in_range_in;
        req_strobe   <= dreq.strobe;
        req_data     <= dreq.data;
      end
    end
  end

  // Reset pulls state out of RESP asynchronously, so a discarded write never commits here.
  always_ff @(posedge clk) begin
    if (state == RESP && req_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (req_strobe[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: vector table plus reset, back-to-back and random-stall sequences.
module tb_dbus_sram_responder;
  import common::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t dresp_a, dresp_b;

  always #5 clk = ~clk;

  dbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u_dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq_a),
    .dresp (dresp_a)
  );

  dbus_sram_responder #(.MEM_WORDS(4096), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq_b),
    .dresp (dresp_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
`ifdef DBUS_RESP_RANDSTALL_EN
    check(name, 64'(lat >= 2 && lat <= 5), 64'd1);
`else
    check(name, 64'(lat), 64'd2);
`endif
  endtask

  // One request on u_dut; entered and left on a falling edge with the DUT back in IDLE.
  task automatic do_req(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data,
                        output logic [63:0] rdata, output int lat);
    dreq_a.valid  = 1'b1;
    dreq_a.addr   = addr;
    dreq_a.size   = 3'd3;
    dreq_a.strobe = strobe;
    dreq_a.data   = data;
    @(posedge clk);
    @(negedge clk);
    dreq_a.valid  = 1'b0;
    dreq_a.addr   = ~addr;
    dreq_a.strobe = ~strobe;
    dreq_a.data   = ~data;
    lat = 1;
    while (!dresp_a.data_ok && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = dresp_a.data;
    if (!dresp_a.data_ok) lat = -1;
    @(negedge clk);
    check("data_ok_single_cycle", 64'(dresp_a.data_ok), 64'd0);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    int          lat;
    logic [7:0]  pat;
    int          seen;
    logic [3:0]  lat_seen;

    vecs[0]  = '{64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    vecs[1]  = '{64'h8000_0000, 8'h00, 64'h0,                   64'h1122_3344_5566_7788};
    vecs[2]  = '{64'h8000_0008, 8'hFF, 64'h0,                   64'h0};
    vecs[3]  = '{64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 64'h0};
    vecs[4]  = '{64'h8000_0008, 8'h00, 64'h0,                   64'h0000_0000_AAAA_BBBB};
    vecs[5]  = '{64'h7FFF_FFF8, 8'h00, 64'h0,                   64'h0};
    vecs[6]  = '{64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0};
    vecs[7]  = '{64'h8000_0000, 8'h00, 64'h0,                   64'h1122_3344_5566_7788};
    vecs[8]  = '{64'h8000_0010, 8'hFF, 64'h0,                   64'h0};
    vecs[9]  = '{64'h8000_0015, 8'h81, 64'hAB12_3456_789A_BCCD, 64'h0};
    vecs[10] = '{64'h8000_0010, 8'h00, 64'h0,                   64'hAB00_0000_0000_00CD};

    reset  = 1'b1;
    dreq_a = '0;
    dreq_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_addr_ok", 64'(dresp_a.addr_ok), 64'd0);
    check("reset_data_ok", 64'(dresp_a.data_ok), 64'd0);
    check("reset_data",    dresp_a.data,         64'd0);
    check("reset_b_ok",    64'(dresp_b.data_ok), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].addr, vecs[i].strobe, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      check_lat($sformatf("vec%0d_latency", i), lat);
    end

    // Reset during WAIT of a write to mem[1]: write must be discarded.
    dreq_a = '{valid: 1'b1, addr: 64'h8000_0008, size: 3'd3, strobe: 8'hFF, data: 64'h5555_5555_5555_5555};
    @(posedge clk);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_data_ok", 64'(dresp_a.data_ok), 64'd0);
    check("midreset_data",    dresp_a.data,         64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dresp_a.data_ok) seen++;
    end
    check("midreset_no_data_ok", 64'(seen), 64'd0);
    do_req(64'h8000_0008, 8'h00, 64'h0, rd, lat);
    check("midreset_mem1_unchanged", rd, 64'h0000_0000_AAAA_BBBB);

    // Reset while a read response is on the bus clears it at once.
    dreq_a = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    @(posedge clk);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    lat = 1;
    while (!dresp_a.data_ok && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_before_reset", dresp_a.data, 64'h1122_3344_5566_7788);
    reset = 1'b1;
    #1;
    check("resp_reset_data_ok", 64'(dresp_a.data_ok), 64'd0);
    check("resp_reset_data",    dresp_a.data,         64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifndef DBUS_RESP_RANDSTALL_EN
    // LATENCY=1 with valid held: data_ok in cycles 1, 3, 5 only.
    pat = 8'b0010_1010;
    dreq_b = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    for (int c = 0; c < 8; c++) begin
      if (c == 5) dreq_b.valid = 1'b0;
      check($sformatf("b2b_cycle%0d", c), 64'(dresp_b.data_ok), 64'(pat[c]));
      @(negedge clk);
    end
`else
    pat = 8'h00;
    lat_seen = 4'b0000;
    for (int n = 0; n < 1000; n++) begin
      do_req(64'h8000_0000, 8'h00, 64'h0, rd, lat);
      check("rand_data", rd, 64'h1122_3344_5566_7788);
      check_lat("rand_latency", lat);
      if (lat >= 2 && lat <= 5) lat_seen[lat-2] = 1'b1;
    end
    check("rand_all_latencies_seen", 64'(lat_seen), 64'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
